// File: rtl/snoop_bus_arbiter_if.sv
// Shared snooping bus between the cache controllers and the arbiter.
// Cores drive requests through master; the arbiter answers through slave.
interface snoop_bus_arbiter_if #(
    parameter int NUM_CORES = 4
);
    logic [NUM_CORES-1:0]    bus_request;
    logic [NUM_CORES-1:0]    bus_rw;
    logic [32*NUM_CORES-1:0] bus_addr;
    logic [32*NUM_CORES-1:0] bus_data_out;
    logic [NUM_CORES-1:0]    bus_grant;
    logic [31:0]             bus_data_in;
    logic [NUM_CORES-1:0]    snoop_hit;
    logic [31:0]             snoop_addr;
    logic                    busy;

    modport master (
        output bus_request, bus_rw, bus_addr, bus_data_out,
        input  bus_grant, bus_data_in, snoop_hit, snoop_addr, busy
    );

    modport slave (
        input  bus_request, bus_rw, bus_addr, bus_data_out,
        output bus_grant, bus_data_in, snoop_hit, snoop_addr, busy
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin snooping bus arbiter with invalidate broadcast and a
// small word-addressed backing memory (1 KiB window, aliased above).
module snoop_bus_arbiter #(
    parameter int NUM_CORES   = 4,
    parameter int MEM_DEPTH   = 256,
    parameter int MEM_LATENCY = 2
) (
    input logic                clk,
    input logic                reset,
    snoop_bus_arbiter_if.slave bus
);
    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {IDLE, SNOOP, MEM, GRANT} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [IW-1:0] last;
    logic [IW-1:0] win;
    logic [IW-1:0] pick;
    logic          rw;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   mem [MEM_DEPTH];
    logic [7:0]    idx;

    // First requester strictly after the previous winner, wrapping.
    function automatic logic [IW-1:0] rr_pick(
        input logic [NUM_CORES-1:0] req,
        input logic [IW-1:0]        prev
    );
        logic [IW-1:0] sel;
        logic          found;
        int            j;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            j = (int'(prev) + k) % NUM_CORES;
            if (!found && req[j]) begin
                found = 1'b1;
                sel   = IW'(j);
            end
        end
        return sel;
    endfunction

    assign pick = rr_pick(bus.bus_request, last);
    assign idx  = addr[9:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            last            <= IW'(NUM_CORES - 1);
            win             <= '0;
            rw              <= 1'b0;
            addr            <= '0;
            wdata           <= '0;
            bus.bus_grant   <= '0;
            bus.bus_data_in <= '0;
            bus.snoop_hit   <= '0;
            bus.snoop_addr  <= '0;
            bus.busy        <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (|bus.bus_request) begin
                        win            <= pick;
                        rw             <= bus.bus_rw[pick];
                        addr           <= bus.bus_addr[32*pick +: 32];
                        wdata          <= bus.bus_data_out[32*pick +: 32];
                        bus.snoop_addr <= bus.bus_addr[32*pick +: 32];
                        bus.snoop_hit  <= bus.bus_rw[pick]
                            ? ~(NUM_CORES'(1) << pick) : '0;
                        bus.busy       <= 1'b1;
                        state          <= SNOOP;
                    end
                end
                SNOOP: begin
                    bus.snoop_hit  <= '0;
                    bus.snoop_addr <= '0;
                    cnt            <= 4'(MEM_LATENCY - 1);
                    state          <= MEM;
                end
                MEM: begin
                    if (cnt == 4'd0) begin
                        // Write data is echoed back so the owner sees its commit.
                        if (rw) begin
                            mem[idx]        <= wdata;
                            bus.bus_data_in <= wdata;
                        end else begin
                            bus.bus_data_in <= mem[idx];
                        end
                        bus.bus_grant <= NUM_CORES'(1) << win;
                        state         <= GRANT;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                GRANT: begin
                    bus.bus_grant   <= '0;
                    bus.bus_data_in <= '0;
                    bus.busy        <= 1'b0;
                    last            <= win;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Randomized bench for snoop_bus_arbiter against a transaction-level
// model that tracks each transfer by its cycle offset since arbitration.
module tb_snoop_bus_arbiter;
    localparam int N = 4;
    localparam int L = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    snoop_bus_arbiter_if #(.NUM_CORES(N)) bi ();

    snoop_bus_arbiter #(
        .NUM_CORES  (N),
        .MEM_DEPTH  (256),
        .MEM_LATENCY(L)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bi)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic         s_rst;
    logic [N-1:0] s_req;
    logic [N-1:0] s_rw;
    logic [31:0]  s_addr [N];
    logic [31:0]  s_wd   [N];

    // Model: phase 0 = bus free, else cycles elapsed since arbitration.
    int          m_phase;
    int          m_win;
    int          m_last;
    logic        m_rw;
    logic [31:0] m_addr;
    logic [31:0] m_wd;
    logic [31:0] m_rd;
    logic [31:0] m_mem [256];
    bit          armed = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit found;
        if (s_rst) begin
            m_phase = 0;
            m_last  = N - 1;
            foreach (m_mem[i]) m_mem[i] = '0;
            armed = 1;
        end else if (m_phase == 0) begin
            if (s_req != '0) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_last + k) % N;
                    if (!found && s_req[j]) begin
                        found = 1;
                        m_win = j;
                    end
                end
                m_rw    = s_rw[m_win];
                m_addr  = s_addr[m_win];
                m_wd    = s_wd[m_win];
                m_phase = 1;
            end
        end else if (m_phase == 2 + L) begin
            m_phase = 0;
            m_last  = m_win;
        end else begin
            if (m_phase == 1 + L) begin
                if (m_rw) m_mem[m_addr[9:2]] = m_wd;
                else m_rd = m_mem[m_addr[9:2]];
            end
            m_phase++;
        end
    endtask

    task automatic tick();
        logic [31:0] eg, es, esa, ed;
        @(negedge clk);
        if (armed) begin
            eg  = '0;
            es  = '0;
            esa = '0;
            ed  = '0;
            if (m_phase == 1) begin
                esa = m_addr;
                if (m_rw) es = ((32'd1 << N) - 1) & ~(32'd1 << m_win);
            end
            if (m_phase == 2 + L) begin
                eg = 32'd1 << m_win;
                ed = m_rw ? m_wd : m_rd;
            end
            chk("grant", 32'(bi.bus_grant), eg);
            chk("data_in", bi.bus_data_in, ed);
            chk("snoop_hit", 32'(bi.snoop_hit), es);
            chk("snoop_addr", bi.snoop_addr, esa);
            chk("busy", 32'(bi.busy), 32'(m_phase != 0));
        end
        reset          = s_rst;
        bi.bus_request = s_req;
        bi.bus_rw      = s_rw;
        for (int i = 0; i < N; i++) begin
            bi.bus_addr[32*i +: 32]     = s_addr[i];
            bi.bus_data_out[32*i +: 32] = s_wd[i];
        end
        model_step();
    endtask

    // One-cycle request pulse; the core then scrambles its address/data.
    task automatic op(input int c, input logic w, input logic [31:0] a,
                      input logic [31:0] d);
        s_req    = '0;
        s_req[c] = 1'b1;
        s_rw[c]  = w;
        s_addr[c] = a;
        s_wd[c]  = d;
        tick();
        s_req    = '0;
        s_addr[c] = $urandom;
        s_wd[c]  = $urandom;
        repeat (6) tick();
    endtask

    initial begin
        s_rst = 1'b1;
        s_req = '0;
        s_rw  = '0;
        for (int i = 0; i < N; i++) begin
            s_addr[i] = '0;
            s_wd[i]   = '0;
        end
        tick();
        tick();
        s_rst = 1'b0;

        op(2, 1'b0, 32'h40, 32'h0);
        op(0, 1'b1, 32'h10, 32'hDEADBEEF);
        op(1, 1'b0, 32'h10, 32'h0);
        op(1, 1'b1, 32'h0000_0404, 32'h55);
        op(3, 1'b0, 32'h0000_0004, 32'h0);

        s_req     = 4'b1000;
        s_rw[3]   = 1'b1;
        s_addr[3] = 32'h20;
        s_wd[3]   = 32'h1234;
        tick();
        s_req = '0;
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        repeat (4) tick();
        op(0, 1'b0, 32'h20, 32'h0);

        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        s_req = '1;
        s_rw  = '0;
        repeat (25) tick();
        s_req = '0;
        repeat (6) tick();

        for (int n = 0; n < 1500; n++) begin
            bit burst;
            burst = ((n / 200) % 2) == 1;
            s_rst = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < N; i++) begin
                s_req[i] = burst ? ($urandom_range(0, 3) != 0)
                                 : ($urandom_range(0, 4) == 0);
                s_rw[i]  = 1'($urandom);
                s_addr[i] = ($urandom & 32'hFFFF_FC03)
                          | (32'($urandom_range(0, 7)) << 2);
                s_wd[i]  = $urandom;
            end
            tick();
        end

        s_rst = 1'b0;
        s_req = '0;
        repeat (8) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
